cs_frame_driver: RTL and testbench

Upstream driver for the computational-system (CS) averaging core. The host pushes a frame of 8-bit samples into this block over a valid/ready handshake, and the block buffers the whole frame. It then pulses the core's reset and streams one sample per clock into the core's X input, because the core has no enable and cannot stall. It captures each valid Y result (window of 9 full) and returns it with a one-cycle valid strobe, plus done/err status.

---
 rtl/cs_frame_driver_pkg.sv | 21 ++
 rtl/cs_frame_driver_fifo.sv | 53 +++++
 rtl/cs_frame_driver.sv | 122 ++++++++++++
 tb/tb_cs_frame_driver.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cs_frame_driver_pkg.sv
// Shared types and constants for the CS averaging-core frame driver.
// Frame-length legality lives here so the top and its users agree on it.
package cs_frame_driver_pkg;

  localparam int CS_WIN   = 9;
  localparam int SAMPLE_W = 8;
  localparam int RESULT_W = 10;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FILL   = 3'd1,
    CSRST  = 3'd2,
    STREAM = 3'd3,
    DRAIN  = 3'd4
  } state_t;

  function automatic logic len_ok(input int len, input int win, input int depth);
    return (len >= win) && (len <= depth);
  endfunction

endpackage

// File: rtl/cs_frame_driver_fifo.sv
// Synchronous DEPTH x DW sample buffer with push/pop/flush and occupancy count.
// The head is read combinationally so the driver can register it straight into cs_x.
module cs_sample_fifo #(
  parameter int DEPTH = 64,
  parameter int CNT_W = 7,
  parameter int DW    = 8
) (
  input  logic             clk,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [DW-1:0]    wdata,
  output logic [DW-1:0]    rdata,
  output logic [CNT_W-1:0] count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic          do_push;
  logic          do_pop;

  function automatic logic [AW-1:0] wrap_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  assign do_push = push && (count != CNT_W'(DEPTH));
  assign do_pop  = pop && (count != '0);
  assign rdata   = mem[rptr];

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wptr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (flush) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wrap_inc(wptr);
      if (do_pop)  rptr <= wrap_inc(rptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/cs_frame_driver.sv
// Buffers a host frame, then resets the CS core and streams it one sample per clock,
// capturing every full-window result. The core cannot stall, hence the full-frame buffer.
module cs_frame_driver
  import cs_frame_driver_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int LEN_W = 7,
  parameter int WIN   = CS_WIN
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [LEN_W-1:0]    frame_len,
  input  logic [SAMPLE_W-1:0] in_data,
  input  logic                in_valid,
  output logic                in_ready,
  output logic                cs_reset,
  output logic [SAMPLE_W-1:0] cs_x,
  input  logic [RESULT_W-1:0] cs_y,
  output logic [RESULT_W-1:0] out_y,
  output logic                out_valid,
  output logic                busy,
  output logic                done,
  output logic                err
);

  state_t              state;
  logic [LEN_W-1:0]    len;
  logic [LEN_W-1:0]    cnt;
  logic [LEN_W-1:0]    fifo_count;
  logic [SAMPLE_W-1:0] head;
  logic                push;
  logic                pop;
  logic                last_stream;

  assign in_ready    = (state == FILL);
  assign busy        = (state != IDLE);
  assign push        = in_valid && in_ready;
  assign last_stream = (cnt == len - LEN_W'(1));
  // cs_x is registered, so each sample is popped as it is loaded for the following cycle
  assign pop         = (state == CSRST) || ((state == STREAM) && !last_stream);

  cs_sample_fifo #(
    .DEPTH (DEPTH),
    .CNT_W (LEN_W),
    .DW    (SAMPLE_W)
  ) u_fifo (
    .clk   (clk),
    .flush (reset),
    .push  (push),
    .pop   (pop),
    .wdata (in_data),
    .rdata (head),
    .count (fifo_count)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      len       <= '0;
      cnt       <= '0;
      cs_reset  <= 1'b1;
      cs_x      <= '0;
      out_y     <= '0;
      out_valid <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      cs_reset  <= 1'b0;
      case (state)
        IDLE: begin
          cs_x <= '0;
          if (start) begin
            if (len_ok(int'(frame_len), WIN, DEPTH)) begin
              len   <= frame_len;
              cnt   <= '0;
              state <= FILL;
            end else begin
              err <= 1'b1;
            end
          end
        end
        FILL: begin
          if (push && (fifo_count + LEN_W'(1) == len)) begin
            cs_reset <= 1'b1;
            state    <= CSRST;
          end
        end
        CSRST: begin
          cs_x  <= head;
          cnt   <= '0;
          state <= STREAM;
        end
        STREAM: begin
          // the core holds samples 0..cnt-1, so its window is full from cnt == WIN
          if (cnt >= LEN_W'(WIN)) begin
            out_y     <= cs_y;
            out_valid <= 1'b1;
          end
          if (last_stream) begin
            cs_x  <= '0;
            state <= DRAIN;
          end else begin
            cs_x <= head;
            cnt  <= cnt + LEN_W'(1);
          end
        end
        DRAIN: begin
          out_y     <= cs_y;
          out_valid <= 1'b1;
          done      <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cs_frame_driver.sv
// Bench for cs_frame_driver: emulates the CS core (9-sample window, y = (2*sum)>>3)
// and checks captured results against window sums computed directly from the frame.
module tb_cs_frame_driver;

  localparam int DEPTH = 64;
  localparam int LEN_W = 7;
  localparam int WIN   = 9;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             start = 1'b0;
  logic [LEN_W-1:0] frame_len = '0;
  logic [7:0]       in_data = '0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic             cs_reset;
  logic [7:0]       cs_x;
  logic [9:0]       cs_y;
  logic [9:0]       out_y;
  logic             out_valid;
  logic             busy;
  logic             done;
  logic             err;

  int n_checks = 0;
  int n_pass   = 0;

  cs_frame_driver #(.DEPTH(DEPTH), .LEN_W(LEN_W), .WIN(WIN)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .frame_len (frame_len),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .cs_reset  (cs_reset),
    .cs_x      (cs_x),
    .cs_y      (cs_y),
    .out_y     (out_y),
    .out_valid (out_valid),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  // CS core emulation: shift register of the last WIN samples, combinational output
  logic [7:0] hist [WIN];
  int         core_sum;

  always @(posedge clk) begin
    if (cs_reset) begin
      for (int i = 0; i < WIN; i++) hist[i] <= 8'd0;
    end else begin
      for (int i = WIN - 1; i > 0; i--) hist[i] <= hist[i-1];
      hist[0] <= cs_x;
    end
  end

  always_comb begin
    core_sum = 0;
    for (int i = 0; i < WIN; i++) core_sum = core_sum + int'(hist[i]);
    cs_y = 10'((core_sum * 2) >> 3);
  end

  // frame contents and results collected by drive_frame
  int   smp [DEPTH];
  int   got [$];
  int   rst_pulses, rst_cyc, first_v, last_v, done_cnt, done_cyc, late_ready;
  bit   timed_out;
  logic done_after;

  function automatic int exp_y(input int k);
    int s = 0;
    for (int j = 0; j < WIN; j++) s += smp[k + j];
    return (2 * s) >> 3;
  endfunction

  // Starts a frame from a negedge, feeds smp[0..len-1], and collects everything until done.
  task automatic drive_frame(input int len, input bit gappy);
    int pushed = 0;
    int cyc = 0;
    bit seen_done = 0;
    got.delete();
    rst_pulses = 0; rst_cyc = -1; first_v = -1; last_v = -1;
    done_cnt = 0; done_cyc = -1; late_ready = 0; timed_out = 0;
    start = 1'b1;
    frame_len = LEN_W'(len);
    @(negedge clk);
    start = 1'b0;
    while (!seen_done && cyc < 400) begin
      if (out_valid) begin
        got.push_back(int'(out_y));
        last_v = cyc;
        if (first_v < 0) first_v = cyc;
      end
      if (cs_reset) begin rst_pulses++; rst_cyc = cyc; end
      if (done) begin seen_done = 1; done_cnt++; done_cyc = cyc; end
      if (pushed >= len && in_ready) late_ready++;
      if (pushed < len) begin
        in_valid = gappy ? ((cyc % 2) == 0) : 1'b1;
        in_data  = 8'(smp[pushed]);
      end else begin
        in_valid = 1'b1;
        in_data  = 8'hEE;
      end
      if (in_valid && in_ready) pushed++;
      cyc++;
      @(negedge clk);
    end
    in_valid = 1'b0;
    done_after = done;
    timed_out = !seen_done;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({cs_reset, out_valid, busy, in_ready, done, err} !== 6'b100000) $display("FAIL reset_flags got=%b want=100000", {cs_reset, out_valid, busy, in_ready, done, err});
    else n_pass++;
    n_checks++;
    if (cs_x !== 8'd0 || out_y !== 10'd0) $display("FAIL reset_data cs_x=%0d out_y=%0d want 0/0", cs_x, out_y);
    else n_pass++;
    reset = 1'b0;
    @(negedge clk);
    for (int i = 0; i < WIN; i++) smp[i] = 10;
    drive_frame(9, 0);
    n_checks++;
    if (timed_out || got.size() != 1) $display("FAIL all10_count got=%0d timeout=%0d want=1", got.size(), timed_out);
    else n_pass++;
    n_checks++;
    if (got.size() < 1 || got[0] != 22 || exp_y(0) != 22) $display("FAIL all10_value got=%0d want=22", (got.size() > 0) ? got[0] : -1);
    else n_pass++;
    n_checks++;
    if (done_cnt != 1 || done_after !== 1'b0) $display("FAIL all10_done pulses=%0d after=%b want 1/0", done_cnt, done_after);
    else n_pass++;
  endtask

  task automatic test_ramp();
    for (int i = 0; i < 10; i++) smp[i] = i + 1;
    drive_frame(10, 0);
    n_checks++;
    if (got.size() != 2 || got[0] != 11 || got[1] != 13) $display("FAIL ramp_values n=%0d first=%0d want n=2 11,13", got.size(), (got.size() > 0) ? got[0] : -1);
    else n_pass++;
    n_checks++;
    if (rst_pulses != 1) $display("FAIL ramp_csreset pulses=%0d want=1", rst_pulses);
    else n_pass++;
    n_checks++;
    if (first_v - rst_cyc != WIN + 2) $display("FAIL ramp_latency got=%0d want=%0d", first_v - rst_cyc, WIN + 2);
    else n_pass++;
    n_checks++;
    if (done_cyc != last_v || late_ready != 0) $display("FAIL ramp_done done_cyc=%0d last_valid=%0d late_ready=%0d", done_cyc, last_v, late_ready);
    else n_pass++;
  endtask

  task automatic test_gappy();
    int bad = 0;
    for (int i = 0; i < 12; i++) smp[i] = int'($urandom_range(0, 255));
    drive_frame(12, 1);
    n_checks++;
    if (got.size() != 12 - WIN + 1) $display("FAIL gappy_count got=%0d want=%0d", got.size(), 12 - WIN + 1);
    else n_pass++;
    for (int k = 0; k < got.size() && k <= 12 - WIN; k++) if (got[k] != exp_y(k)) bad++;
    n_checks++;
    if (bad != 0 || timed_out) $display("FAIL gappy_values mismatches=%0d timeout=%0d want 0", bad, timed_out);
    else n_pass++;
  endtask

  task automatic test_illegal();
    int lens [3] = '{8, DEPTH + 1, 0};
    foreach (lens[n]) begin
      start = 1'b1;
      frame_len = LEN_W'(lens[n]);
      in_valid = 1'b1;
      @(negedge clk);
      start = 1'b0;
      n_checks++;
      if ({err, busy, in_ready} !== 3'b100) $display("FAIL illegal_len%0d err/busy/ready=%b want=100", lens[n], {err, busy, in_ready});
      else n_pass++;
      @(negedge clk);
      n_checks++;
      if ({err, busy, in_ready} !== 3'b000) $display("FAIL illegal_len%0d_after err/busy/ready=%b want=000", lens[n], {err, busy, in_ready});
      else n_pass++;
      in_valid = 1'b0;
    end
  endtask

  task automatic test_full();
    int bad = 0;
    for (int i = 0; i < DEPTH; i++) smp[i] = int'($urandom_range(0, 255));
    drive_frame(DEPTH, 0);
    n_checks++;
    if (got.size() != DEPTH - WIN + 1 || timed_out) $display("FAIL full_count got=%0d want=%0d", got.size(), DEPTH - WIN + 1);
    else n_pass++;
    for (int k = 0; k < got.size() && k <= DEPTH - WIN; k++) if (got[k] != exp_y(k)) bad++;
    n_checks++;
    if (bad != 0) $display("FAIL full_values mismatches=%0d want=0", bad);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    int stale = 0;
    int waited = 0;
    for (int i = 0; i < 20; i++) smp[i] = int'($urandom_range(0, 255));
    start = 1'b1;
    frame_len = LEN_W'(20);
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 20; i++) begin
      in_valid = 1'b1;
      in_data = 8'(smp[i]);
      @(negedge clk);
    end
    in_valid = 1'b0;
    while (!cs_reset && waited < 20) begin waited++; @(negedge clk); end
    n_checks++;
    if (!cs_reset) $display("FAIL midrst_csrst_seen got=0 want=1");
    else n_pass++;
    repeat (WIN + 4) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({out_valid, cs_reset, busy, in_ready} !== 4'b0100) $display("FAIL midrst_state got=%b want=0100", {out_valid, cs_reset, busy, in_ready});
    else n_pass++;
    reset = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (out_valid || done) stale++;
    end
    n_checks++;
    if (stale != 0) $display("FAIL midrst_stale strobes=%0d want=0", stale);
    else n_pass++;
    for (int i = 0; i < WIN; i++) smp[i] = 10;
    drive_frame(9, 0);
    n_checks++;
    if (got.size() != 1 || got[0] != 22 || done_cnt != 1) $display("FAIL midrst_frame n=%0d first=%0d done=%0d want 1/22/1", got.size(), (got.size() > 0) ? got[0] : -1, done_cnt);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_ramp();
    test_gappy();
    test_illegal();
    test_full();
    test_gappy();
    test_full();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
